bus_arbiter: RTL and testbench
==============================

Name: bus_arbiter

Overview:
- Shares the single 32-bit internal CPU bus between NUM_REQ requesters, e.g. control unit, I/O port logic and debug/loader.
- Arbitrates round-robin, then sequences one two-cycle register-to-register transfer per grant.
- Drives the 24 one-hot source out-enables of the bus mux (R0out..R15out, HIout, LOout, ZHIout, ZLOout, PCout, MDRout, PortInout, CSignout) and a one-hot destination load-enable vector.
- Guarantees at most one source enable is ever active.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- NUM_DST, 24, number of destination load enables.
- SEL_W, 5, width of each source/destination select field.

Ports:
- clock  in  1  system clock, rising edge.
- clear  in  1  asynchronous, active-high reset.
- req  in  NUM_REQ  per-requester transfer request (level).
- src_sel  in  NUM_REQ*SEL_W  packed source index per requester; requester i uses bits [i*SEL_W +: SEL_W].
- dst_sel  in  NUM_REQ*SEL_W  packed destination index per requester, same packing.
- lock  in  NUM_REQ  hold-grant request; used only with BUS_ARB_LOCK_EN.
- gnt  out  NUM_REQ  one-hot grant, held for the whole transfer.
- ack  out  NUM_REQ  one-cycle completion pulse to the granted requester.
- src_oe  out  24  one-hot bus mux source enables. Index order: 0-15 = R0-R15, 16 HI, 17 LO, 18 ZHI, 19 ZLO, 20 PC, 21 MDR, 22 PortIn, 23 CSign.
- dst_ie  out  NUM_DST  one-hot destination load enable.
- sel_err  out  1  one-cycle pulse: an out-of-range select was rejected.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset: clear is asynchronous and active-high.
  - Asserting it forces state=IDLE, rr_ptr=NUM_REQ-1, and gnt, ack, src_oe, dst_ie, sel_err, busy all to 0.
  - Reset mid-transfer aborts the transfer with no ack.
- All outputs are registered. Nothing is combinational from the inputs.
- States: IDLE, DRIVE, LATCH.
- IDLE:
  - If any req bit is set, pick the first set bit searching upward from rr_ptr+1, wrapping modulo NUM_REQ.
  - Capture that requester's src_sel and dst_sel, assert its gnt, set rr_ptr to its index, go to DRIVE.
  - If no req bit is set, stay in IDLE.
- Select check at capture: if src_sel>=24 or dst_sel>=NUM_DST, do not enter DRIVE.
  - Instead pulse ack and sel_err together for one cycle, with gnt asserted that cycle and src_oe=dst_ie=0.
  - Then return to IDLE.
- DRIVE (1 cycle): src_oe = one-hot of the captured source; dst_ie=0; the bus settles.
- LATCH (1 cycle):
  - src_oe is held; dst_ie = one-hot of the captured destination, so the destination register loads at the end of this cycle.
  - ack is pulsed for the granted requester.
  - Next state is IDLE. gnt, src_oe and dst_ie drop on entry to IDLE.
- Latency: req seen in IDLE at cycle 0 -> src_oe high in cycles 1-2 -> dst_ie and ack in cycle 2 -> next grant can be issued at cycle 3 at the earliest.
- Requester rules:
  - Hold req until ack. Selects are sampled only at grant and may change afterwards.
  - Dropping req after grant does not cancel the transfer.
  - A requester whose req is still high after its ack is treated as a new request and re-arbitrated.
- Fairness: with all requesters active, grant order is 0,1,2,...,NUM_REQ-1,0...
- src_sel==dst_sel index (e.g. src R3, dst R3) is legal and is performed.

Optional Feature:
- Macro: BUS_ARB_LOCK_EN.
- Enabled: if lock[i] of the granted requester is high at the cycle of its ack, the next state is DRIVE with gnt kept, not IDLE.
  - The new src_sel/dst_sel are re-captured and validated in that ack cycle.
  - An invalid re-captured select pulses sel_err on the following cycle with no enables, then goes to IDLE.
  - Back-to-back transfers therefore take 2 cycles each.
  - The lock is released when lock is low at ack time, and rr_ptr advances normally.
- Disabled: the lock port is ignored and every transfer returns to IDLE.

Decomposition:
- Shared package bus_pkg holds:
  - NUM_SRC=24 and SEL_W=5.
  - Source index constants SRC_R0..SRC_R15, SRC_HI, SRC_LO, SRC_ZHI, SRC_ZLO, SRC_PC, SRC_MDR, SRC_PORTIN, SRC_CSIGN.
  - The arbiter state enum.
- One sub-module: rr_picker.
  - Combinational round-robin first-set search from rr_ptr+1.
  - Outputs found flag and index. Reusable by the memory port arbiter.

Test Plan:
- Reset mid-LATCH: assert clear during LATCH -> all outputs 0 immediately; no ack; next grant after release goes to req0.
- Single transfer: req[1]=1, src_sel1=20 (PC), dst_sel1=5 -> gnt=0010 at cycle 1; src_oe=1<<20 in cycles 1-2; dst_ie=1<<5 and ack=0010 at cycle 2; busy low at cycle 3.
- Contention: req=1111 held with valid selects -> ack order 0,1,2,3,0 at 3-cycle spacing; src_oe never has more than 1 bit set (assertion checked every cycle).
- Bad select: req[2]=1, src_sel2=27 -> sel_err=1 and ack=0100 in the same cycle; src_oe and dst_ie remain 0.
- Req drop: req[0] deasserted in the cycle after grant -> transfer still completes with ack at cycle 2.
- BUS_ARB_LOCK_EN on, lock[3]=1 for 3 transfers with src 21, 16, 23 -> acks 2 cycles apart; gnt=1000 held throughout; no other requester is granted until lock drops.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared definitions for the internal CPU bus: source indices, select width
// and the arbiter state encoding.
package bus_pkg;

    localparam int NUM_SRC = 24;
    localparam int SEL_W   = 5;

    localparam logic [SEL_W-1:0] SRC_R0     = 5'd0;
    localparam logic [SEL_W-1:0] SRC_R1     = 5'd1;
    localparam logic [SEL_W-1:0] SRC_R2     = 5'd2;
    localparam logic [SEL_W-1:0] SRC_R3     = 5'd3;
    localparam logic [SEL_W-1:0] SRC_R4     = 5'd4;
    localparam logic [SEL_W-1:0] SRC_R5     = 5'd5;
    localparam logic [SEL_W-1:0] SRC_R6     = 5'd6;
    localparam logic [SEL_W-1:0] SRC_R7     = 5'd7;
    localparam logic [SEL_W-1:0] SRC_R8     = 5'd8;
    localparam logic [SEL_W-1:0] SRC_R9     = 5'd9;
    localparam logic [SEL_W-1:0] SRC_R10    = 5'd10;
    localparam logic [SEL_W-1:0] SRC_R11    = 5'd11;
    localparam logic [SEL_W-1:0] SRC_R12    = 5'd12;
    localparam logic [SEL_W-1:0] SRC_R13    = 5'd13;
    localparam logic [SEL_W-1:0] SRC_R14    = 5'd14;
    localparam logic [SEL_W-1:0] SRC_R15    = 5'd15;
    localparam logic [SEL_W-1:0] SRC_HI     = 5'd16;
    localparam logic [SEL_W-1:0] SRC_LO     = 5'd17;
    localparam logic [SEL_W-1:0] SRC_ZHI    = 5'd18;
    localparam logic [SEL_W-1:0] SRC_ZLO    = 5'd19;
    localparam logic [SEL_W-1:0] SRC_PC     = 5'd20;
    localparam logic [SEL_W-1:0] SRC_MDR    = 5'd21;
    localparam logic [SEL_W-1:0] SRC_PORTIN = 5'd22;
    localparam logic [SEL_W-1:0] SRC_CSIGN  = 5'd23;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_LATCH = 2'd2
    } arb_state_e;

    // Decodes a source index into the one-hot mux enable vector.
    function automatic logic [NUM_SRC-1:0] src_onehot(input logic [SEL_W-1:0] sel);
        src_onehot = {{(NUM_SRC-1){1'b0}}, 1'b1} << sel;
    endfunction

endpackage

// File: rtl/bus_arbiter_rr_picker.sv
// Round-robin first-set search starting one above ptr_i, wrapping modulo N.
module rr_picker #(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic          found_o,
    output logic [PW-1:0] idx_o
);

    // Scan farthest-first so the nearest set bit after ptr_i wins.
    always_comb begin
        found_o = 1'b0;
        idx_o   = {PW{1'b0}};
        for (int k = N; k >= 1; k--) begin
            found_o = found_o | req_i[(int'(ptr_i) + k) % N];
            idx_o   = req_i[(int'(ptr_i) + k) % N] ? PW'((int'(ptr_i) + k) % N) : idx_o;
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin owner of the 32-bit CPU bus: one DRIVE+LATCH transfer per grant.
// Optional macro BUS_ARB_LOCK_EN lets a locked requester chain transfers.
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int NUM_DST = 24,
    parameter int SEL_W   = 5
) (
    input  logic                     clock,
    input  logic                     clear,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*SEL_W-1:0] src_sel,
    input  logic [NUM_REQ*SEL_W-1:0] dst_sel,
    input  logic [NUM_REQ-1:0]       lock,
    output logic [NUM_REQ-1:0]       gnt,
    output logic [NUM_REQ-1:0]       ack,
    output logic [NUM_SRC-1:0]       src_oe,
    output logic [NUM_DST-1:0]       dst_ie,
    output logic                     sel_err,
    output logic                     busy
);

    localparam int PW = $clog2(NUM_REQ);

    arb_state_e          state_q, state_d;
    logic [PW-1:0]       rr_ptr_q, rr_ptr_d;
    logic [SEL_W-1:0]    src_q, src_d, dst_q, dst_d;
    logic [NUM_REQ-1:0]  gnt_q, gnt_d, ack_q, ack_d;
    logic [NUM_SRC-1:0]  src_oe_q, src_oe_d;
    logic [NUM_DST-1:0]  dst_ie_q, dst_ie_d;
    logic                sel_err_q, sel_err_d, busy_q, busy_d;

    logic                found_s;
    logic [PW-1:0]       pick_s;
    logic [SEL_W-1:0]    pick_src_s, pick_dst_s, own_src_s, own_dst_s;
    logic                pick_ok_s, own_ok_s;

    rr_picker #(.N(NUM_REQ), .PW(PW)) u_picker (
        .req_i   (req),
        .ptr_i   (rr_ptr_q),
        .found_o (found_s),
        .idx_o   (pick_s)
    );

    assign pick_src_s = src_sel[int'(pick_s) * SEL_W +: SEL_W];
    assign pick_dst_s = dst_sel[int'(pick_s) * SEL_W +: SEL_W];
    assign own_src_s  = src_sel[int'(rr_ptr_q) * SEL_W +: SEL_W];
    assign own_dst_s  = dst_sel[int'(rr_ptr_q) * SEL_W +: SEL_W];
    assign pick_ok_s  = (32'(pick_src_s) < 32'(NUM_SRC)) && (32'(pick_dst_s) < 32'(NUM_DST));
    assign own_ok_s   = (32'(own_src_s) < 32'(NUM_SRC)) && (32'(own_dst_s) < 32'(NUM_DST));

`ifndef BUS_ARB_LOCK_EN
    logic unused_lock_s;
    assign unused_lock_s = ^{lock, own_ok_s};
`endif

    // Next-state and next-output computation; every output is registered.
    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        src_d     = src_q;
        dst_d     = dst_q;
        gnt_d     = gnt_q;
        ack_d     = {NUM_REQ{1'b0}};
        src_oe_d  = src_oe_q;
        dst_ie_d  = {NUM_DST{1'b0}};
        sel_err_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                gnt_d    = {NUM_REQ{1'b0}};
                src_oe_d = {NUM_SRC{1'b0}};
                // The cycle showing a rejection pulse still belongs to that request.
                if (found_s && (ack_q == {NUM_REQ{1'b0}}) && !sel_err_q) begin
                    rr_ptr_d = pick_s;
                    src_d    = pick_src_s;
                    dst_d    = pick_dst_s;
                    gnt_d    = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_s;
                    if (pick_ok_s) begin
                        state_d  = ST_DRIVE;
                        src_oe_d = src_onehot(pick_src_s);
                    end else begin
                        ack_d     = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_s;
                        sel_err_d = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DRIVE: begin
                state_d  = ST_LATCH;
                dst_ie_d = {{(NUM_DST-1){1'b0}}, 1'b1} << dst_q;
                ack_d    = gnt_q;
            end
            ST_LATCH: begin
`ifdef BUS_ARB_LOCK_EN
                if (lock[rr_ptr_q]) begin
                    src_d = own_src_s;
                    dst_d = own_dst_s;
                    if (own_ok_s) begin
                        state_d  = ST_DRIVE;
                        src_oe_d = src_onehot(own_src_s);
                    end else begin
                        state_d   = ST_IDLE;
                        src_oe_d  = {NUM_SRC{1'b0}};
                        sel_err_d = 1'b1;
                    end
                end else begin
                    state_d  = ST_IDLE;
                    gnt_d    = {NUM_REQ{1'b0}};
                    src_oe_d = {NUM_SRC{1'b0}};
                end
`else
                state_d  = ST_IDLE;
                gnt_d    = {NUM_REQ{1'b0}};
                src_oe_d = {NUM_SRC{1'b0}};
`endif
            end
            default: begin
                state_d  = ST_IDLE;
                gnt_d    = {NUM_REQ{1'b0}};
                src_oe_d = {NUM_SRC{1'b0}};
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q   <= ST_IDLE;
            rr_ptr_q  <= PW'(NUM_REQ - 1);
            src_q     <= {SEL_W{1'b0}};
            dst_q     <= {SEL_W{1'b0}};
            gnt_q     <= {NUM_REQ{1'b0}};
            ack_q     <= {NUM_REQ{1'b0}};
            src_oe_q  <= {NUM_SRC{1'b0}};
            dst_ie_q  <= {NUM_DST{1'b0}};
            sel_err_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            src_q     <= src_d;
            dst_q     <= dst_d;
            gnt_q     <= gnt_d;
            ack_q     <= ack_d;
            src_oe_q  <= src_oe_d;
            dst_ie_q  <= dst_ie_d;
            sel_err_q <= sel_err_d;
            busy_q    <= busy_d;
        end
    end

    assign gnt     = gnt_q;
    assign ack     = ack_q;
    assign src_oe  = src_oe_q;
    assign dst_ie  = dst_ie_q;
    assign sel_err = sel_err_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter; the lock sequence runs when BUS_ARB_LOCK_EN is defined.
module tb_bus_arbiter;

    logic        clock = 1'b0;
    logic        clear;
    logic [3:0]  req, lock, gnt, ack;
    logic [19:0] src_sel, dst_sel;
    logic [23:0] src_oe, dst_ie;
    logic        sel_err, busy;
    int          total = 0;
    int          bad   = 0;

    bus_arbiter #(.NUM_REQ(4), .NUM_DST(24), .SEL_W(5)) dut (
        .clock   (clock),
        .clear   (clear),
        .req     (req),
        .src_sel (src_sel),
        .dst_sel (dst_sel),
        .lock    (lock),
        .gnt     (gnt),
        .ack     (ack),
        .src_oe  (src_oe),
        .dst_ie  (dst_ie),
        .sel_err (sel_err),
        .busy    (busy)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic nc();
        @(negedge clock);
    endtask

    // Source enables must never have more than one bit set.
    always @(negedge clock) begin
        total++;
        assert ($countones(src_oe) <= 1) else begin
            bad++;
            $error("FAIL src_oe_onehot observed=%h expected=at most one bit", src_oe);
        end
    end

    initial begin
        clear = 1'b1; req = 4'b0000; lock = 4'b0000;
        src_sel = 20'd0; dst_sel = 20'd0;
        nc(); nc();
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_ack", 32'(ack), 32'h0);
        chk("rst_src_oe", 32'(src_oe), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        clear = 1'b0;
        nc();

        // Single transfer: requester 1, PC -> dst 5.
        src_sel[5 +: 5] = 5'd20; dst_sel[5 +: 5] = 5'd5; req = 4'b0010;
        nc();
        chk("t1_gnt_c1", 32'(gnt), 32'h2);
        chk("t1_src_c1", 32'(src_oe), 32'h0010_0000);
        chk("t1_dst_c1", 32'(dst_ie), 32'h0);
        chk("t1_busy_c1", 32'(busy), 32'h1);
        nc();
        chk("t1_src_c2", 32'(src_oe), 32'h0010_0000);
        chk("t1_dst_c2", 32'(dst_ie), 32'h0000_0020);
        chk("t1_ack_c2", 32'(ack), 32'h2);
        req = 4'b0000;
        nc();
        chk("t1_busy_c3", 32'(busy), 32'h0);
        chk("t1_gnt_c3", 32'(gnt), 32'h0);
        chk("t1_ack_c3", 32'(ack), 32'h0);

        // Req dropped after grant; src==dst (R3 -> R3) still performed.
        src_sel[0 +: 5] = 5'd3; dst_sel[0 +: 5] = 5'd3; req = 4'b0001;
        nc();
        chk("t2_gnt_c1", 32'(gnt), 32'h1);
        req = 4'b0000;
        nc();
        chk("t2_ack_c2", 32'(ack), 32'h1);
        chk("t2_src_c2", 32'(src_oe), 32'h0000_0008);
        chk("t2_dst_c2", 32'(dst_ie), 32'h0000_0008);
        nc();
        chk("t2_busy_c3", 32'(busy), 32'h0);

        // Bad source select on requester 2.
        src_sel[10 +: 5] = 5'd27; dst_sel[10 +: 5] = 5'd1; req = 4'b0100;
        nc();
        chk("t3_sel_err", 32'(sel_err), 32'h1);
        chk("t3_ack", 32'(ack), 32'h4);
        chk("t3_gnt", 32'(gnt), 32'h4);
        chk("t3_src_oe", 32'(src_oe), 32'h0);
        chk("t3_dst_ie", 32'(dst_ie), 32'h0);
        req = 4'b0000;
        nc();
        chk("t3_sel_err_c2", 32'(sel_err), 32'h0);
        chk("t3_ack_c2", 32'(ack), 32'h0);
        chk("t3_src_oe_c2", 32'(src_oe), 32'h0);

        // Bad destination select on requester 3.
        src_sel[15 +: 5] = 5'd0; dst_sel[15 +: 5] = 5'd30; req = 4'b1000;
        nc();
        chk("t4_sel_err", 32'(sel_err), 32'h1);
        chk("t4_ack", 32'(ack), 32'h8);
        chk("t4_dst_ie", 32'(dst_ie), 32'h0);
        req = 4'b0000;
        nc();

        // Contention: all four requesting, pointer at 3 -> order 0,1,2,3,0.
        src_sel = {5'd23, 5'd22, 5'd17, 5'd16};
        dst_sel = {5'd3, 5'd2, 5'd1, 5'd0};
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            nc();
            chk($sformatf("t5_gnt_%0d", k), 32'(gnt), 32'(4'b0001 << (k % 4)));
            nc();
            chk($sformatf("t5_ack_%0d", k), 32'(ack), 32'(4'b0001 << (k % 4)));
            nc();
            chk($sformatf("t5_gap_%0d", k), 32'(ack), 32'h0);
        end
        req = 4'b0000;
        nc(); nc(); nc();

        // Reset during LATCH: requester 2 is aborted, next grant goes to 0.
        src_sel[10 +: 5] = 5'd4; dst_sel[10 +: 5] = 5'd6; req = 4'b0100;
        nc();
        chk("t6_gnt_c1", 32'(gnt), 32'h4);
        nc();
        clear = 1'b1;
        #1;
        chk("t6_ack_clr", 32'(ack), 32'h0);
        chk("t6_gnt_clr", 32'(gnt), 32'h0);
        chk("t6_src_clr", 32'(src_oe), 32'h0);
        chk("t6_dst_clr", 32'(dst_ie), 32'h0);
        chk("t6_busy_clr", 32'(busy), 32'h0);
        nc();
        chk("t6_ack_hold", 32'(ack), 32'h0);
        clear = 1'b0; req = 4'b1111;
        nc();
        chk("t6_gnt_after", 32'(gnt), 32'h1);
        nc();
        chk("t6_ack_after", 32'(ack), 32'h1);
        req = 4'b0000;
        nc(); nc();

`ifdef BUS_ARB_LOCK_EN
        // Locked chain on requester 3: MDR, HI, CSign; requester 1 waits.
        src_sel[15 +: 5] = 5'd21; dst_sel[15 +: 5] = 5'd1;
        src_sel[5 +: 5] = 5'd2; dst_sel[5 +: 5] = 5'd2;
        lock = 4'b1000; req = 4'b1000;
        nc();
        chk("t7_gnt_c1", 32'(gnt), 32'h8);
        chk("t7_src_c1", 32'(src_oe), 32'h0020_0000);
        req = 4'b1010;
        nc();
        chk("t7_ack_c2", 32'(ack), 32'h8);
        src_sel[15 +: 5] = 5'd16;
        nc();
        chk("t7_gnt_c3", 32'(gnt), 32'h8);
        chk("t7_src_c3", 32'(src_oe), 32'h0001_0000);
        chk("t7_ack_c3", 32'(ack), 32'h0);
        nc();
        chk("t7_ack_c4", 32'(ack), 32'h8);
        chk("t7_gnt_c4", 32'(gnt), 32'h8);
        src_sel[15 +: 5] = 5'd23;
        nc();
        chk("t7_gnt_c5", 32'(gnt), 32'h8);
        chk("t7_src_c5", 32'(src_oe), 32'h0080_0000);
        lock = 4'b0000; req = 4'b0010;
        nc();
        chk("t7_ack_c6", 32'(ack), 32'h8);
        chk("t7_gnt_c6", 32'(gnt), 32'h8);
        nc();
        chk("t7_gnt_c7", 32'(gnt), 32'h0);
        nc();
        chk("t7_gnt_c8", 32'(gnt), 32'h2);
        nc();
        chk("t7_ack_c9", 32'(ack), 32'h2);
        req = 4'b0000;
        nc(); nc();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
